// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
module id_ex_operand_stage #(
   parameter int XLEN   = 32,
   parameter int RIDX_W = 5,
   parameter int OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [RIDX_W-1:0] id_rs1,
   input  logic [RIDX_W-1:0] id_rs2,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [RIDX_W-1:0] id_rd,
   input  logic              id_rd_we,
   input  logic              id_is_load,
   input  logic [OP_W-1:0]   id_alu_op,
   input  logic              id_a_sel_pc,
   input  logic              id_b_sel_imm,
   input  logic              stall,
   input  logic              flush,
   input  logic [RIDX_W-1:0] mem_rd,
   input  logic              mem_rd_we,
   input  logic [XLEN-1:0]   mem_data,
   input  logic [RIDX_W-1:0] wb_rd,
   input  logic              wb_rd_we,
   input  logic [XLEN-1:0]   wb_data,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_alu_a,
   output logic [XLEN-1:0]   ex_alu_b,
   output logic [OP_W-1:0]   ex_alu_op,
   output logic [XLEN-1:0]   ex_store_data,
   output logic [XLEN-1:0]   ex_pc,
   output logic [RIDX_W-1:0] ex_rd,
   output logic              ex_rd_we,
   output logic              ex_is_load,
   output logic              load_use_stall
);

   // registered source indices, operand data and selects kept for EX forwarding
   logic [RIDX_W-1:0] ex_rs1;
   logic [RIDX_W-1:0] ex_rs2;
   logic [XLEN-1:0]   ex_rs1_data;
   logic [XLEN-1:0]   ex_rs2_data;
   logic [XLEN-1:0]   ex_imm;
   logic              ex_a_sel_pc;
   logic              ex_b_sel_imm;

   logic [XLEN-1:0]   cap_rs1_data;
   logic [XLEN-1:0]   cap_rs2_data;
   logic [XLEN-1:0]   fwd_rs1;
   logic [XLEN-1:0]   fwd_rs2;
   logic              wb_hit_id1;
   logic              wb_hit_id2;
   logic              mem_hit1;
   logic              mem_hit2;
   logic              wb_hit1;
   logic              wb_hit2;

   // load-use detection: a load in EX feeding an ID source; masked while downstream stalls
   always_comb begin
      load_use_stall = 1'b0;
      if (!stall && ex_valid && ex_is_load && (ex_rd != '0) && id_valid &&
          ((id_rs1 == ex_rd) || ((id_rs2 == ex_rd) && !id_b_sel_imm)))
         load_use_stall = 1'b1;
   end

   // capture bypass: a retiring WB write the regfile read could not yet see
   always_comb begin
      wb_hit_id1   = wb_rd_we && (wb_rd != '0) && (wb_rd == id_rs1);
      wb_hit_id2   = wb_rd_we && (wb_rd != '0) && (wb_rd == id_rs2);
      cap_rs1_data = wb_hit_id1 ? wb_data : id_rs1_data;
      cap_rs2_data = wb_hit_id2 ? wb_data : id_rs2_data;
   end

   // stage register: reset and bubble clear everything, stall holds, otherwise capture
   always_ff @(posedge clk) begin
      if (rst || (!stall && (flush || load_use_stall))) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_rd        <= '0;
         ex_rd_we     <= 1'b0;
         ex_is_load   <= 1'b0;
         ex_alu_op    <= '0;
         ex_a_sel_pc  <= 1'b0;
         ex_b_sel_imm <= 1'b0;
      end else if (!stall) begin
         ex_valid     <= id_valid;
         ex_pc        <= id_pc;
         ex_rs1       <= id_rs1;
         ex_rs2       <= id_rs2;
         ex_rs1_data  <= cap_rs1_data;
         ex_rs2_data  <= cap_rs2_data;
         ex_imm       <= id_imm;
         ex_rd        <= id_rd;
         ex_rd_we     <= id_valid && id_rd_we;
         ex_is_load   <= id_valid && id_is_load;
         ex_alu_op    <= id_alu_op;
         ex_a_sel_pc  <= id_a_sel_pc;
         ex_b_sel_imm <= id_b_sel_imm;
      end
   end

   // EX forwarding: EX/MEM beats MEM/WB, x0 is never forwarded
   always_comb begin
      mem_hit1 = mem_rd_we && (mem_rd != '0) && (mem_rd == ex_rs1);
      mem_hit2 = mem_rd_we && (mem_rd != '0) && (mem_rd == ex_rs2);
      wb_hit1  = wb_rd_we && (wb_rd != '0) && (wb_rd == ex_rs1);
      wb_hit2  = wb_rd_we && (wb_rd != '0) && (wb_rd == ex_rs2);
      fwd_rs1  = mem_hit1 ? mem_data : (wb_hit1 ? wb_data : ex_rs1_data);
      fwd_rs2  = mem_hit2 ? mem_data : (wb_hit2 ? wb_data : ex_rs2_data);
   end

   // ALU operand selection and store data
   always_comb begin
      ex_alu_a      = ex_a_sel_pc ? ex_pc : fwd_rs1;
      ex_alu_b      = ex_b_sel_imm ? ex_imm : fwd_rs2;
      ex_store_data = fwd_rs2;
   end

endmodule
